// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_sequencer
// Description : Two-stage pipeline that sequences multi-word add/subtract
//               through an external combinational adder, LS word first.
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_sequencer #(
  parameter int N     = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_cout,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_CONT  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_s1_valid;
  logic [N-1:0]     r_s1_a;
  logic [N-1:0]     r_s1_b;
  logic             r_s1_last;
  logic             r_s1_first;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_sub;
  logic             r_carry;

  logic             w_adv;
  logic             w_accept;
  logic             w_move;

  assign w_adv    = !out_valid | out_ready;
  assign in_ready = !r_s1_valid | w_adv;
  assign w_accept = in_valid & in_ready;
  assign w_move   = r_s1_valid & w_adv;

  // r_sub always belongs to the word in S1: it is only rewritten when a new
  // first word enters S1, and S1 holds one word at a time.
  assign add_a   = r_s1_a;
  assign add_b   = r_s1_b ^ {N{r_sub}};
  assign add_cin = r_s1_first ? r_sub : r_carry;

  // Stage S1 and the operation-tracking FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FIRST;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b1;
      r_s1_idx   <= '0;
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
    end else begin
      if (w_move) begin
        r_carry <= add_cout;
      end
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_last  <= in_last;
        r_s1_first <= (r_state == ST_FIRST);
        case (r_state)
          ST_FIRST: begin
            r_sub    <= in_sub;
            r_s1_idx <= '0;
            r_state  <= in_last ? ST_FIRST : ST_CONT;
          end
          default: begin
            r_s1_idx <= r_s1_idx + IDX_W'(1);
            r_state  <= in_last ? ST_FIRST : ST_CONT;
          end
        endcase
      end else if (w_move) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage S2: output register, frozen while stalled by out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_sum  <= add_sum;
        out_last <= r_s1_last;
        out_idx  <= r_s1_idx;
        out_cout <= add_cout;
        out_ovf  <= add_cout ^ (add_sum[N-1] ^ add_a[N-1] ^ add_b[N-1]);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 The module SHALL have parameter N, default 32, giving the word width of the operand and sum datapath.
REQ-002 The module SHALL have parameter IDX_W, default 4, giving the width of the word-index counter.
REQ-003 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: an upstream operand word is present.
REQ-006 Port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 Port in_a and port in_b, inputs, N bits each: operand words, least-significant word first.
REQ-008 Port in_sub, input, 1 bit: subtract (a-b); it is sampled only on the first word of an operation.
REQ-009 Port in_last, input, 1 bit: this is the final word of the operation.
REQ-010 Ports add_a and add_b, outputs, N bits each, and port add_cin, output, 1 bit: these drive the external combinational adder.
REQ-011 Port add_sum, input, N bits, and port add_cout, input, 1 bit: the combinational result returned from the adder.
REQ-012 Port out_valid, output, 1 bit, and port out_ready, input, 1 bit: the result handshake.
REQ-013 Port out_sum, output, N bits: the result word.
REQ-014 Port out_last, output, 1 bit: marks the final result word.
REQ-015 Port out_idx, output, IDX_W bits: the position of the result word within its operation.
REQ-016 Port out_cout, output, 1 bit: the final carry (no-borrow when subtracting); it is meaningful only when out_last=1.
REQ-017 Port out_ovf, output, 1 bit: signed overflow of the whole operation; it is meaningful only when out_last=1.

Function
REQ-018 A transfer SHALL occur when in_valid=1 and in_ready=1; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-019 The block SHALL be a two-stage pipeline: stage S1 holds the operand registers that drive the adder, and stage S2 is the output register.
REQ-020 Stage S1 SHALL advance when S2 is empty or S2 is being drained (adv = !out_valid | out_ready).
REQ-021 in_ready SHALL equal !s1_valid | adv, giving one word per cycle at full throughput.
REQ-022 Latency SHALL be one word accepted at edge k appearing on out_* after edge k+1 when there is no backpressure.
REQ-023 The FSM SHALL have two states: FIRST (the next S1 word starts an operation) and CONT (carry_reg and sub_reg are valid).
REQ-024 On acceptance of a word in FIRST, the block SHALL capture in_sub into sub_reg.
REQ-025 On acceptance of a word in FIRST, the block SHALL move to CONT unless in_last=1.
REQ-026 On acceptance of a word in CONT, the block SHALL stay in CONT unless in_last=1, which returns it to FIRST.
REQ-027 Adder drive SHALL be add_a = s1_a.
REQ-028 Adder drive SHALL be add_b = s1_b XOR {N{s1_sub}}.
REQ-029 add_cin SHALL equal s1_sub for the first word of an operation and carry_reg otherwise.
REQ-030 When S1 advances into S2, the block SHALL capture carry_reg <= add_cout.
REQ-031 When S1 advances into S2, the block SHALL capture out_sum <= add_sum.
REQ-032 When S1 advances into S2, the block SHALL capture out_last <= s1_last and out_cout <= add_cout.
REQ-033 When S1 advances into S2, the block SHALL capture out_ovf <= add_cout XOR (add_sum[N-1] ^ add_a[N-1] ^ add_b[N-1]).
REQ-034 out_idx SHALL be 0 on the first word of an operation and increment per word, wrapping modulo 2^IDX_W with no error flag.
REQ-035 S2 contents SHALL hold stable while out_valid=1 and out_ready=0.
REQ-036 On simultaneous drain of S2 and fill from S1 in the same cycle, no bubble SHALL be inserted and no data SHALL be lost.
REQ-037 A single-word operation (in_last=1 on the first word) SHALL be legal, and back-to-back operations SHALL need no idle cycle.

Reset
REQ-038 While rst=1, the block SHALL force s1_valid=0, out_valid=0, the FSM to FIRST, and carry_reg=0 and sub_reg=0.
REQ-039 While rst=1, the block SHALL force out_sum=0, out_last=0, out_idx=0, out_cout=0 and out_ovf=0.
REQ-040 While rst=1, in_ready SHALL read 1 (S1 is empty), and add_a, add_b and add_cin SHALL read 0.
REQ-041 Reset mid-operation SHALL discard any partial operation, so that the first word after reset is treated as the first word of a new operation.

Verification
REQ-042 The bench SHALL check a single-word add of a=FFFFFFFF, b=00000001, sub=0, last=1 -> out_sum=00000000, cout=1, ovf=0, idx=0, with out_valid two edges after acceptance.
REQ-043 The bench SHALL check a two-word add of word0 {FFFFFFFF, 00000001} followed by word1 {00000000, 00000000, last} -> sums 00000000 then 00000001, final cout=0, idx 0 then 1.
REQ-044 The bench SHALL check a subtract of a=5, b=7, sub=1, last=1 -> out_sum=FFFFFFFE, cout=0, ovf=0.
REQ-045 The bench SHALL check a signed-overflow add of a=7FFFFFFF, b=00000001 -> out_sum=80000000, ovf=1, cout=0.
REQ-046 The bench SHALL check backpressure: with out_ready=0 and in_valid=1 held, in_ready=0 after two accepted words, S2 stays stable, and all words emerge in order with correct carries once out_ready=1.
REQ-047 The bench SHALL check reset mid-operation: rst pulsed after word0 of a two-word add -> out_valid=0, then a new word a=1, b=1, sub=0 yields out_sum=2, idx=0, with carry_reg ignored.
